if_fetch: RTL and testbench

- Instruction fetch unit for the RV32 core. It produces the PC/instruction stream that the if_id register hands to the decoder (inst_addr/inst).
- It drives a req/gnt/rvalid instruction bus and buffers returned words in a small in-order FIFO.
- It presents them downstream with valid/ready.
- It redirects on jump_flag_i from ex, discarding stale in-flight fetches.

---
 rtl/if_fetch_if.sv | 41 ++++
 rtl/if_fetch.sv | 151 +++++++++++++++
 tb/tb_if_fetch.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if: instruction-bus bundle between the fetch unit and memory.
//
// Signals (named from the fetch unit's point of view):
//   ibus_req_o     fetch request
//   ibus_addr_o    word-aligned fetch address
//   ibus_gnt_i     request accepted this cycle
//   ibus_rvalid_i  read data valid (in order, at least one cycle after gnt)
//   ibus_rdata_i   instruction word
//
// Handshake: a fetch is issued in every cycle where ibus_req_o & ibus_gnt_i
// are both high. While gnt is low the master holds req and addr unchanged,
// except that a redirect may retarget a request that has not been granted.
// Each issued fetch gets exactly one rvalid, in issue order, no earlier than
// the cycle after its gnt; rvalid has no back-pressure.
//
// Modports: master = fetch unit, slave = memory / bus model.
// ---------------------------------------------------------------------------
interface if_fetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_gnt_i,
        input  ibus_rvalid_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_gnt_i,
        output ibus_rvalid_i,
        output ibus_rdata_i
    );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch: RV32 instruction fetch unit.
//
// Issues sequential word fetches on the req/gnt/rvalid bus, buffers returned
// words with their PC in an in-order FIFO, and presents them to if_id with
// valid/ready. A jump from ex redirects the PC, flushes the FIFO and marks
// every fetch still in flight as stale so its response is dropped.
//
// Ports:
//   clk, rst          core clock, asynchronous active-low reset
//   ibus              if_fetch_if.master (req/addr out, gnt/rvalid/rdata in)
//   jump_flag_i       redirect request from ex
//   jump_addr_i       redirect target (low two bits ignored)
//   inst_valid_o      inst_o / inst_addr_o valid
//   inst_ready_i      if_id accepts; pop = inst_valid_o & inst_ready_i
//   inst_o            instruction word (NOP when empty)
//   inst_addr_o       PC of inst_o (0 when empty)
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  ibus,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    // PC of the next live (non-stale) response; responses return in order
    // and live fetches are sequential from the last redirect, so one
    // running address replaces a queue of per-fetch addresses.
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] disc_cnt_q, disc_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   addr_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];

    logic        pop;
    logic        issue;
    logic        disc_resp;
    logic        live_resp;
    logic        push;
    logic [31:0] used;
    logic [31:0] jump_tgt;
    logic        unused_jump_lsbs;

    assign unused_jump_lsbs = ^jump_addr_i[1:0];
    assign jump_tgt         = {jump_addr_i[31:2], 2'b00};

    // Output side
    assign inst_valid_o = (cnt_q != '0);
    assign inst_o       = inst_valid_o ? data_mem_q[rd_ptr_q] : NOP;
    assign inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : 32'h0;
    assign pop          = inst_valid_o & inst_ready_i;

    // Credit rule: buffered + in flight (live and stale) must stay below
    // FIFO_DEPTH after this cycle's pop, so every response has a slot.
    assign used = 32'(cnt_q) + 32'(out_cnt_q) + 32'(disc_cnt_q) - 32'(pop);
    assign ibus.ibus_req_o  = rst & (used < FIFO_DEPTH);
    assign ibus.ibus_addr_o = pc_q;

    assign issue     = ibus.ibus_req_o & ibus.ibus_gnt_i;
    assign disc_resp = ibus.ibus_rvalid_i & (disc_cnt_q != '0);
    // An rvalid with nothing counted (e.g. left over from before reset) is
    // neither live nor stale and is ignored.
    assign live_resp = ibus.ibus_rvalid_i & (disc_cnt_q == '0) & (out_cnt_q != '0);
    assign push      = live_resp & ~jump_flag_i;

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        cnt_d      = cnt_q;
        out_cnt_d  = out_cnt_q;
        disc_cnt_d = disc_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (jump_flag_i) begin
            // Everything in flight, including a fetch granted right now,
            // becomes stale; a response arriving now retires one of them.
            pc_d       = jump_tgt;
            resp_pc_d  = jump_tgt;
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            out_cnt_d  = '0;
            disc_cnt_d = disc_cnt_q + out_cnt_q + CW'(issue)
                       - CW'(disc_resp | live_resp);
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            out_cnt_d  = out_cnt_q + CW'(issue) - CW'(live_resp);
            disc_cnt_d = disc_cnt_q - CW'(disc_resp);
            if (push) begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                addr_mem_q[i] <= 32'h0;
                data_mem_q[i] <= NOP;
            end
        end else if (push) begin
            addr_mem_q[wr_ptr_q] <= resp_pc_q;
            data_mem_q[wr_ptr_q] <= ibus.ibus_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch: self-checking bench for if_fetch.
//
// The bench owns a bus/memory model (grants, in-order responses after a
// chosen latency) and a reference model of the fetch unit's observable
// behaviour: the expected fetch PC, the expected instruction buffer content
// (exp_q) and redirect epochs that decide which responses are stale.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] bus_addr;
        logic [31:0] exp_addr;
        int          epoch;
        int          due;
    } pend_t;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_fetch_if ibus();
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b1;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    if_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ibus         (ibus),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    // ------------------------------------------------------------ model state
    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] m_pc = RPC;
    int          m_epoch = 0;
    int          cyc = 0;
    int          first_pop_cyc = -1;
    int          lat = 1;
    int          gnt_mode = 1;   // 0 never, 1 always, 2 random
    int          rdy_mode = 1;   // 0 never, 1 always, 2 random
    logic        last_req;
    logic [31:0] last_req_addr;
    int          n_assert = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ibus.ibus_gnt_i    = 1'b0;
        ibus.ibus_rvalid_i = 1'b0;
        ibus.ibus_rdata_i  = 32'h0;
        jump_flag_i        = 1'b0;
        #1;
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_inst",  inst_o, NOP);
        check("rst_addr",  inst_addr_o, 32'h0);
        check("rst_req",   ibus.ibus_req_o, 1'b0);
        pend.delete();
        exp_q.delete();
        got_q.delete();
        m_pc = RPC;
        m_epoch++;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0;
        first_pop_cyc = -1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by what the coming posedge does.
    task automatic step(input logic j, input logic [31:0] ja, input logic orphan);
        logic        gnt;
        logic        rv;
        logic        exp_req;
        logic        exp_pop;
        pend_t       e;
        @(negedge clk);
        jump_flag_i  = j;
        jump_addr_i  = ja;
        inst_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        gnt = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
        rv  = orphan || (pend.size() > 0 && pend[0].due <= cyc);
        ibus.ibus_gnt_i    = gnt;
        ibus.ibus_rvalid_i = rv;
        ibus.ibus_rdata_i  = orphan ? 32'hDEAD_BEEF : (rv ? mem_word(pend[0].bus_addr) : 32'h0);
        #1;

        check("valid", inst_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("inst_addr", inst_addr_o, exp_q[0][63:32]);
            check("inst", inst_o, exp_q[0][31:0]);
        end else begin
            check("inst_nop", inst_o, NOP);
            check("inst_addr_zero", inst_addr_o, 32'h0);
        end
        exp_pop = (exp_q.size() != 0) && inst_ready_i;
        exp_req = (exp_q.size() + pend.size() - int'(exp_pop)) < DEPTH;
        check("req", ibus.ibus_req_o, exp_req);
        if (ibus.ibus_req_o) check("fetch_addr", ibus.ibus_addr_o, m_pc);
        last_req      = ibus.ibus_req_o;
        last_req_addr = ibus.ibus_addr_o;

        if (inst_valid_o && inst_ready_i && !j) begin
            got_q.push_back(inst_addr_o);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (exp_pop && !j) void'(exp_q.pop_front());
        if (rv && !orphan) begin
            e = pend.pop_front();
            if (!j && e.epoch == m_epoch)
                exp_q.push_back({e.exp_addr, mem_word(e.bus_addr)});
        end
        if (ibus.ibus_req_o && gnt)
            pend.push_back('{ibus.ibus_addr_o, m_pc, m_epoch, cyc + lat});
        if (j) begin
            exp_q.delete();
            m_epoch++;
            m_pc = {ja[31:2], 2'b00};
        end else if (ibus.ibus_req_o && gnt) begin
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic found;
        ibus.ibus_gnt_i    = 1'b0;
        ibus.ibus_rvalid_i = 1'b0;
        ibus.ibus_rdata_i  = 32'h0;

        // 1: streaming from reset, 1-cycle responses
        do_reset();
        gnt_mode = 1; rdy_mode = 1; lat = 1;
        run(12);
        check("t1_first_valid_cycle", first_pop_cyc, 2);
        check("t1_addr0", got_at(0), 32'h0);
        check("t1_addr1", got_at(1), 32'h4);
        check("t1_addr2", got_at(2), 32'h8);
        check("t1_throughput", got_q.size(), 10);

        // 2: back-pressure with head at 0x10
        step(1'b1, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (exp_q.size() != 0 && exp_q[0][63:32] == 32'h10) found = 1'b1;
            else step(1'b0, 32'h0, 1'b0);
        end
        check("t2_align", found, 1'b1);
        got_q.delete();
        rdy_mode = 0;
        run(5);
        check("t2_req_dropped", last_req, 1'b0);
        rdy_mode = 1;
        run(6);
        check("t2_addr0", got_at(0), 32'h10);
        check("t2_addr1", got_at(1), 32'h14);
        check("t2_addr2", got_at(2), 32'h18);

        // 3: redirect with two fetches in flight
        lat = 3;
        step(1'b1, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend.size() == 2 && pend[0].epoch == m_epoch && pend[0].due > cyc) found = 1'b1;
            else step(1'b0, 32'h0, 1'b0);
        end
        check("t3_align", found, 1'b1);
        step(1'b1, 32'h100, 1'b0);
        got_q.delete();
        run(14);
        check("t3_addr0", got_at(0), 32'h100);
        check("t3_addr1", got_at(1), 32'h104);

        // 4: redirect coinciding with gnt(0x20) and rvalid(0x1C)
        lat = 1;
        step(1'b1, 32'h0, 1'b0);
        got_q.delete();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_pc == 32'h20 && pend.size() != 0 && pend[0].exp_addr == 32'h1C) found = 1'b1;
            else step(1'b0, 32'h0, 1'b0);
        end
        check("t4_align", found, 1'b1);
        step(1'b1, 32'h203, 1'b0);
        check("t4_stale_granted", last_req_addr, 32'h20);
        found = 1'b0;
        foreach (got_q[i]) if (got_q[i] == 32'h1C) found = 1'b1;
        check("t4_no_1c", found, 1'b0);
        got_q.delete();
        step(1'b0, 32'h0, 1'b0);
        check("t4_next_req", last_req_addr, 32'h200);
        run(6);
        check("t4_first", got_at(0), 32'h200);

        // 5: grant wait states
        step(1'b1, 32'h40, 1'b0);
        gnt_mode = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0);
            check("t5_req_held", last_req, 1'b1);
            check("t5_addr_held", last_req_addr, 32'h40);
        end
        gnt_mode = 1;
        got_q.delete();
        run(8);
        check("t5_addr0", got_at(0), 32'h40);
        check("t5_addr1", got_at(1), 32'h44);

        // 6: address wrap, then reset mid-stream and a leftover response
        step(1'b1, 32'hFFFF_FFF8, 1'b0);
        got_q.delete();
        run(6);
        check("t6_wrap0", got_at(0), 32'hFFFF_FFF8);
        check("t6_wrap1", got_at(1), 32'hFFFF_FFFC);
        check("t6_wrap2", got_at(2), 32'h0);
        lat = 3;
        run(3);
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        run(10);
        check("t6_restart", got_at(0), RPC);

        // randomized traffic
        gnt_mode = 2; rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 15) == 0)
                step(1'b1, $urandom, 1'b0);
            else
                step(1'b0, 32'h0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
